// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Data wins by default; a waiting fetch gets the port after MAX_DATA_RUN back-to-back data grants.
//
// state | meaning
// IDLE  | port free, arbitrating between fetch and data requests
// FETCH | fetch access in flight, waiting for mem_ack
// DATA  | load/store access in flight, waiting for mem_ack
module mem_port_arbiter #(
   parameter int unsigned MAX_DATA_RUN = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [29:0] if_addr,
   input  logic        if_flush,
   output logic        if_valid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic        d_done,
   output logic [31:0] d_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

   localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

   state_t     state, state_nxt;
   logic [3:0] run_cnt;
   logic       drop;
   logic       grant_d, grant_f;

   always_comb begin
      grant_d   = 1'b0;
      grant_f   = 1'b0;
      state_nxt = state;
      case (state)
         IDLE: begin
            grant_d = d_req & ((run_cnt < RUN_MAX) | ~if_req);
            grant_f = ~grant_d & if_req;
            if (grant_d)      state_nxt = DATA;
            else if (grant_f) state_nxt = FETCH;
         end
         FETCH, DATA: begin
            if (mem_ack) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         run_cnt   <= 4'd0;
         drop      <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 30'd0;
         mem_wdata <= 32'd0;
         mem_be    <= 4'd0;
      end else begin
         state <= state_nxt;

         // The run only counts while a fetch is actually waiting.
         if ((state == IDLE) && !if_req)        run_cnt <= 4'd0;
         else if (grant_f)                      run_cnt <= 4'd0;
         else if (grant_d && run_cnt < RUN_MAX) run_cnt <= run_cnt + 4'd1;

         if (state == FETCH) begin
            if (mem_ack)       drop <= 1'b0;
            else if (if_flush) drop <= 1'b1;
         end else begin
            drop <= 1'b0;
         end

         if (grant_d) begin
            mem_we    <= d_we;
            mem_addr  <= d_addr[31:2];
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
         end else if (grant_f) begin
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            mem_be   <= 4'hF;
         end
      end
   end

   assign busy     = (state != IDLE);
   assign mem_req  = busy;
   assign if_valid = (state == FETCH) & mem_ack & ~drop & ~if_flush;
   assign d_done   = (state == DATA) & mem_ack;
   assign if_rdata = mem_rdata;
   assign d_rdata  = mem_rdata;

endmodule
